// File: rtl/serial_sub32_pkg.sv
// Shared definitions for the serial subtractor and the companion serial adder blocks.
package serial_sub32_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub32_if.sv
// Request/result bundle of the serial subtractor: operands and start in, status and results out.
interface serial_sub32_if
  import serial_sub32_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             Zero;
  logic             Ovf;

  modport master (
    output start, In1, In2, Bin,
    input  busy, done, Diff, Bout, Zero, Ovf
  );

  modport slave (
    input  start, In1, In2, Bin,
    output busy, done, Diff, Bout, Zero, Ovf
  );

endinterface

// File: rtl/FS_dataflow.sv
// 1-bit full subtractor: Diff = In1 - In2 - Bin, Bout set when the bit needs a borrow.
module FS_dataflow (
  input  logic In1,
  input  logic In2,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  assign Diff = In1 ^ In2 ^ Bin;
  assign Bout = (~In1 & In2) | (~(In1 ^ In2) & Bin);

endmodule

// File: rtl/serial_sub32.sv
// Bit-serial subtractor: one bit per clock, LSB first, results published together on DONE entry.
module serial_sub32
  import serial_sub32_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_sub32_if.slave        bus
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] diff_sr;
  logic             borrow;
  logic             a_msb;
  logic             b_msb;

  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             zero_q;
  logic             ovf_q;

  logic             fs_diff;
  logic             fs_bout;
  logic             capture;
  logic             step;
  logic             last;
  logic [WIDTH-1:0] diff_full;

  assign capture   = (state == IDLE) && bus.start;
  assign step      = (state == RUN);
  assign last      = step && (cnt == LAST);
  assign diff_full = {fs_diff, diff_sr};

  FS_dataflow u_fs (
    .In1  (a_sr[0]),
    .In2  (b_sr[0]),
    .Bin  (borrow),
    .Diff (fs_diff),
    .Bout (fs_bout)
  );

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Operand shifters and borrow chain; the sign bits are kept aside for the overflow test.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      borrow  <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
    end else if (capture) begin
      a_sr   <= bus.In1;
      b_sr   <= bus.In2;
      borrow <= bus.Bin;
      a_msb  <= bus.In1[WIDTH-1];
      b_msb  <= bus.In2[WIDTH-1];
    end else if (step) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      borrow  <= fs_bout;
      diff_sr <= {fs_diff, diff_sr[WIDTH-2:1]};
    end
  end

  // Result register only moves on the last bit, so no partial difference is ever visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (last) begin
      diff_q <= diff_full;
      bout_q <= fs_bout;
      zero_q <= (diff_full == '0);
      ovf_q  <= (a_msb != b_msb) && (fs_diff != a_msb);
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.Diff = diff_q;
  assign bus.Bout = bout_q;
  assign bus.Zero = zero_q;
  assign bus.Ovf  = ovf_q;

endmodule
